// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : Buffered 8N1 UART receiver. The serial line is synchronised,
//            each bit is sampled at mid-bit, and the start and stop bits are
//            checked. Good bytes go into a first-word fall-through FIFO that
//            the consumer drains at its own pace.
// Ports    : CLK        - system clock, rising edge
//            RST        - synchronous active-high reset
//            RX_IN      - asynchronous serial line, idle high
//            rd_en      - pop the head entry (ignored while empty)
//            data_out   - FIFO head, valid while empty==0
//            empty      - FIFO holds no entries
//            full       - FIFO holds FIFO_DEPTH entries
//            count      - number of entries held
//            frame_err  - 1-cycle pulse, stop bit sampled low
//            overrun    - 1-cycle pulse, good byte dropped because FIFO full
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int CLK_PER_BITS = 1086,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          RX_IN,
  input  logic                          rd_en,
  output logic [7:0]                    data_out,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int              AW        = $clog2(FIFO_DEPTH);
  localparam int              CW        = $clog2(CLK_PER_BITS);
  localparam logic [CW-1:0]   BIT_LAST  = CW'(CLK_PER_BITS - 1);
  localparam logic [CW-1:0]   BIT_HALF  = CW'((CLK_PER_BITS - 1) / 2);
  localparam logic [AW:0]     DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

  // --------------------------------------------------------------------------
  // Two-flop synchroniser; resets to the idle (high) line level so a reset
  // never looks like a start bit.
  // --------------------------------------------------------------------------
  logic rx_meta;
  logic rx_s;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX_IN;
      rx_s    <= rx_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Receive FSM
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_WAIT_HI = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] clk_cnt;
  logic [CW-1:0] clk_cnt_nxt;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_idx_nxt;
  logic [7:0]    shift;
  logic [7:0]    shift_nxt;
  logic          stop_sample;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nxt;
      clk_cnt <= clk_cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    stop_sample = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_nxt   = S_START;
          clk_cnt_nxt = '0;
        end
      end
      S_START: begin
        // Half a bit in: a line that is high again was only a glitch.
        if (clk_cnt == BIT_HALF) begin
          clk_cnt_nxt = '0;
          bit_idx_nxt = '0;
          state_nxt   = rx_s ? S_IDLE : S_DATA;
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_nxt        = '0;
          shift_nxt[bit_idx] = rx_s;
          if (bit_idx == 3'd7) begin
            state_nxt = S_STOP;
          end else begin
            bit_idx_nxt = bit_idx + 1'b1;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_nxt = '0;
          stop_sample = 1'b1;
          // A low stop bit may be a break; wait for the line to recover
          // before hunting for the next start bit.
          state_nxt   = rx_s ? S_IDLE : S_WAIT_HI;
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end
      S_WAIT_HI: begin
        if (rx_s) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FIFO
  // --------------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_CNT);
  assign pop   = rd_en && !empty;
  // A same-cycle pop frees a slot, so a full FIFO can still take the byte.
  assign push  = stop_sample && rx_s && (!full || pop);

  assign data_out = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= shift;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      frame_err <= stop_sample && !rx_s;
      overrun   <= stop_sample && rx_s && !push;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Purpose  : Self-checking bench for uart_rx_fifo. Frames are serialised onto
//            the line; a queue model of the FIFO holds the bytes that should
//            be readable, and a monitor compares every pop and every error
//            pulse against it.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 8;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       rx_in = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] data_out;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       frame_err;
  logic       overrun;

  int checks   = 0;
  int failures = 0;
  int fe_seen  = 0;
  int ov_seen  = 0;
  int fe_exp   = 0;
  int ov_exp   = 0;

  // Bytes the FIFO should currently hold, head first.
  logic [7:0] model_q[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLK_PER_BITS (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .RX_IN     (rx_in),
    .rd_en     (rd_en),
    .data_out  (data_out),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: counts pulse cycles and scores every pop against the model.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) fe_seen++;
      if (overrun)   ov_seen++;
      if (frame_err || overrun)
        chk("pulse_exclusive", 32'(frame_err && overrun), 32'd0);
      if (rd_en) begin
        chk("pop_empty_flag", 32'(empty), 32'(model_q.size() == 0));
        if (!empty && model_q.size() > 0)
          chk("pop_data", 32'(data_out), 32'(model_q.pop_front()));
      end
    end
  end

  // Fate of a completed frame, from the line-level rules alone.
  task automatic model_frame(input logic [7:0] b, input bit stop_hi);
    if (!stop_hi)                    fe_exp++;
    else if (model_q.size() == DEPTH) ov_exp++;
    else                             model_q.push_back(b);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_hi, input int extra_low);
    @(posedge clk); #1 rx_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge clk);
      #1 rx_in = b[i];
    end
    repeat (CPB) @(posedge clk);
    #1 rx_in = stop_hi;
    repeat (CPB) @(posedge clk);
    if (!stop_hi) repeat (extra_low) @(posedge clk);
    #1 rx_in = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Stop bit is sampled 155 edges after the start bit is driven: 2 sync
  // flops + 1 idle detect + 8 half-bit clocks + 9 bit times of 16 clocks.
  task automatic send_with_pop(input logic [7:0] b);
    fork
      send_frame(b, 1'b1, 0);
      begin
        repeat (155) @(posedge clk);
        #1 rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
      end
    join
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      rd_en = 1'b1;
      @(posedge clk);
      #1 rd_en = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_count"},     32'(count),   32'(model_q.size()));
    chk({tag, "_empty"},     32'(empty),   32'(model_q.size() == 0));
    chk({tag, "_full"},      32'(full),    32'(model_q.size() == DEPTH));
    if (model_q.size() > 0)
      chk({tag, "_data"},    32'(data_out), 32'(model_q[0]));
    chk({tag, "_frame_err"}, 32'(fe_seen), 32'(fe_exp));
    chk({tag, "_overrun"},   32'(ov_seen), 32'(ov_exp));
  endtask

  initial begin
    logic [7:0] b;
    bit         good;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_empty",     32'(empty),     32'd1);
    chk("rst_full",      32'(full),      32'd0);
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_data",      32'(data_out),  32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_overrun",   32'(overrun),   32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single good byte, then pop it
    send_frame(8'hA5, 1'b1, 0);
    model_frame(8'hA5, 1'b1);
    chk("a5_head", 32'(data_out), 32'h0000_00A5);
    check_state("a5");
    pop_n(1);
    check_state("a5_pop");

    // Short low glitch must not start a frame
    rx_in = 1'b0;
    repeat (5) @(posedge clk);
    #1 rx_in = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check_state("glitch");

    // Low stop bit followed by a 40-clock break
    send_frame(8'h3C, 1'b0, 40);
    model_frame(8'h3C, 1'b0);
    check_state("ferr");

    // Fill past capacity without reading
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 1'b1, 0);
      model_frame(8'(i), 1'b1);
      if (i == 8) chk("full_after_8", 32'(full), 32'd1);
    end
    check_state("ovr");
    pop_n(8);
    check_state("drain");
    pop_n(1);
    check_state("underflow");

    // Full FIFO with a pop on the stop-sample cycle: byte accepted
    for (int i = 0; i < DEPTH; i++) begin
      send_frame(8'(8'h40 + i), 1'b1, 0);
      model_frame(8'(8'h40 + i), 1'b1);
    end
    send_with_pop(8'h5A);
    model_frame(8'h5A, 1'b1);
    check_state("full_pop");
    pop_n(DEPTH);
    check_state("full_pop_drain");

    // One entry with a pop on the stop-sample cycle: head becomes new byte
    send_frame(8'h11, 1'b1, 0);
    model_frame(8'h11, 1'b1);
    send_with_pop(8'h22);
    model_frame(8'h22, 1'b1);
    check_state("one_pop");
    pop_n(1);

    // Reset mid-DATA with 3 bytes queued
    for (int i = 0; i < 3; i++) begin
      send_frame(8'(8'hC0 + i), 1'b1, 0);
      model_frame(8'(8'hC0 + i), 1'b1);
    end
    fork
      send_frame(8'hFF, 1'b1, 0);
      begin
        repeat (61) @(posedge clk);
        #1 rst = 1'b1;
        model_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_empty", 32'(empty), 32'd1);
        chk("midrst_count", 32'(count), 32'd0);
      end
    join
    check_state("after_rst");
    send_frame(8'h96, 1'b1, 0);
    model_frame(8'h96, 1'b1);
    check_state("post_rst_frame");
    pop_n(1);

    // Randomised traffic: random bytes, occasional bad stop, random pops
    for (int n = 0; n < 16; n++) begin
      b    = 8'($urandom);
      good = ($urandom_range(0, 7) != 0);
      send_frame(b, good, good ? 0 : int'($urandom_range(0, 20)));
      model_frame(b, good);
      pop_n(int'($urandom_range(0, 3)));
      check_state("rand");
    end
    pop_n(DEPTH + 1);
    check_state("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
